// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with prefetch queue, branch target table and halt
module fetch_unit #(
   parameter int P = 12,
   parameter int W = 9,
   parameter int T = 4,
   parameter int Q = 2,
   parameter int C = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   output logic [P-1:0] RomAddr,
   input  logic [W-1:0] RomData,
   input  logic         Stall,
   input  logic         BranchEn,
   input  logic [T-1:0] TargSel,
   input  logic         Halt,
   input  logic         LutWe,
   input  logic [T-1:0] LutAddr,
   input  logic [P-1:0] LutData,
   output logic [W-1:0] InstOut,
   output logic [P-1:0] InstPC,
   output logic         InstValid,
   output logic         Done,
   output logic [C-1:0] CycleCt
);

   localparam int QW = (Q > 1) ? $clog2(Q) : 1;
   localparam int CW = $clog2(Q + 1);

   typedef enum logic {RUN, HALTED} fetchState;

   fetchState       state;
   logic [P-1:0]    fetchPc;
   logic [QW-1:0]   head;
   logic [QW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [W-1:0]    qData [Q];
   logic [P-1:0]    qPc [Q];
   logic [P-1:0]    targTable [2**T];

   logic consume;
   logic branchTaken;
   logic haltTaken;
   logic push;

   function automatic logic [QW-1:0] bump(input logic [QW-1:0] idx);
      return (idx == QW'(Q - 1)) ? '0 : idx + QW'(1);
   endfunction

   assign InstValid   = (count != '0);
   assign consume     = InstValid & ~Stall;
   assign branchTaken = consume & BranchEn & ~Halt;
   assign haltTaken   = consume & Halt;
   // A full queue can still accept a fetch when the head leaves the same cycle.
   assign push        = (state == RUN) & ((count < CW'(Q)) | consume) & ~branchTaken & ~haltTaken;

   assign RomAddr = fetchPc;
   assign InstOut = qData[head];
   assign InstPC  = qPc[head];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= RUN;
         Done    <= 1'b0;
         fetchPc <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         CycleCt <= '0;
      end else if (state == RUN) begin
         if (CycleCt != '1)
            CycleCt <= CycleCt + C'(1);
         if (haltTaken) begin
            state <= HALTED;
            Done  <= 1'b1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else if (branchTaken) begin
            fetchPc <= targTable[TargSel];
            head    <= '0;
            tail    <= '0;
            count   <= '0;
         end else begin
            if (push) begin
               tail    <= bump(tail);
               fetchPc <= fetchPc + P'(1);
            end
            if (consume)
               head <= bump(head);
            if (push && !consume)
               count <= count + CW'(1);
            else if (consume && !push)
               count <= count - CW'(1);
         end
      end
   end

   // Queue payload needs no reset: entries are only read while count says they are live.
   always_ff @(posedge Clk) begin
      if (push) begin
         qData[tail] <= RomData;
         qPc[tail]   <= fetchPc;
      end
   end

   // A branch reading the entry being written sees the old value (read before the edge).
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 2**T; i++)
            targTable[i] <= '0;
      end else if (LutWe) begin
         targTable[LutAddr] <= LutData;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam int P = 12;
   localparam int W = 9;
   localparam int T = 4;
   localparam int Q = 2;
   localparam int C = 16;

   logic         Clk = 1'b0;
   logic         Reset;
   logic [P-1:0] RomAddr;
   logic [W-1:0] RomData;
   logic         Stall, BranchEn, Halt, LutWe;
   logic [T-1:0] TargSel, LutAddr;
   logic [P-1:0] LutData;
   logic [W-1:0] InstOut;
   logic [P-1:0] InstPC;
   logic         InstValid, Done;
   logic [C-1:0] CycleCt;

   logic         rst2;
   logic [3:0]   romAddr2, instPc2, cyc2;
   logic [8:0]   romData2, instOut2;
   logic         instValid2, done2;

   int nVec = 0;
   int nErr = 0;

   logic [P-1:0] pcQ[$];
   logic [P-1:0] mPc;
   bit           mHalted;
   int           mCyc;
   logic [P-1:0] mTbl [16];

   always #5 Clk = ~Clk;

   function automatic logic [8:0] romFn(input logic [11:0] a);
      logic [11:0] t;
      t = a * 12'd37 + 12'd5;
      return t[8:0] ^ {a[2:0], a[11:6]};
   endfunction

   function automatic logic [8:0] romFn4(input logic [3:0] a);
      return {a, ~a, 1'b1};
   endfunction

   assign RomData  = romFn(RomAddr);
   assign romData2 = romFn4(romAddr2);

   fetch_unit #(.P(P), .W(W), .T(T), .Q(Q), .C(C)) dut (
      .Clk(Clk), .Reset(Reset), .RomAddr(RomAddr), .RomData(RomData),
      .Stall(Stall), .BranchEn(BranchEn), .TargSel(TargSel), .Halt(Halt),
      .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
      .InstOut(InstOut), .InstPC(InstPC), .InstValid(InstValid),
      .Done(Done), .CycleCt(CycleCt)
   );

   fetch_unit #(.P(4), .W(9), .T(4), .Q(2), .C(4)) dutSmall (
      .Clk(Clk), .Reset(rst2), .RomAddr(romAddr2), .RomData(romData2),
      .Stall(1'b0), .BranchEn(1'b0), .TargSel(4'd0), .Halt(1'b0),
      .LutWe(1'b0), .LutAddr(4'd0), .LutData(4'd0),
      .InstOut(instOut2), .InstPC(instPc2), .InstValid(instValid2),
      .Done(done2), .CycleCt(cyc2)
   );

   task modelReset();
      pcQ.delete();
      mPc = '0;
      mHalted = 0;
      mCyc = 0;
      for (int i = 0; i < 16; i++) mTbl[i] = '0;
   endtask

   // Reference: the queue holds addresses of fetched-but-unconsumed instructions.
   task modelStep();
      bit consume;
      logic [P-1:0] target;
      consume = (pcQ.size() > 0) && !Stall;
      target = mTbl[TargSel];
      if (!mHalted) begin
         if (mCyc < 65535) mCyc++;
         if (consume && Halt) begin
            pcQ.delete();
            mHalted = 1;
         end else if (consume && BranchEn) begin
            pcQ.delete();
            mPc = target;
         end else begin
            if (consume) void'(pcQ.pop_front());
            if (pcQ.size() < Q) begin
               pcQ.push_back(mPc);
               mPc = mPc + 12'd1;
            end
         end
      end
      if (LutWe) mTbl[LutAddr] = LutData;
   endtask

   task tick();
      modelStep();
      @(posedge Clk);
      #1;
   endtask

   task idleInputs();
      Stall = 0; BranchEn = 0; Halt = 0; TargSel = '0;
      LutWe = 0; LutAddr = '0; LutData = '0;
   endtask

   task doReset();
      idleInputs();
      Reset = 1;
      #2;
      modelReset();
      Reset = 0;
   endtask

   task test_reset();
      idleInputs();
      Reset = 1;
      #1;
      nVec++; if (RomAddr !== 12'h000) begin nErr++; $display("FAIL reset_romaddr: got %0h want 0", RomAddr); end
      nVec++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %0b want 0", InstValid); end
      nVec++; if (Done !== 1'b0) begin nErr++; $display("FAIL reset_done: got %0b want 0", Done); end
      nVec++; if (CycleCt !== 16'd0) begin nErr++; $display("FAIL reset_cyclect: got %0d want 0", CycleCt); end
      @(posedge Clk);
      #1;
      modelReset();
      Reset = 0;
      tick();
      BranchEn = 1;
      TargSel = 4'($urandom_range(0, 15));
      tick();
      BranchEn = 0;
      tick();
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h000) begin nErr++; $display("FAIL reset_table_zero: got valid=%0b pc=%0h want 1/0", InstValid, InstPC); end
   endtask

   task test_straight();
      doReset();
      for (int n = 0; n < 25; n++) begin
         nVec++; if (RomAddr !== 12'(n)) begin nErr++; $display("FAIL straight_romaddr[%0d]: got %0h want %0h", n, RomAddr, n); end
         nVec++; if (InstValid !== (n > 0)) begin nErr++; $display("FAIL straight_valid[%0d]: got %0b want %0b", n, InstValid, n > 0); end
         if (n > 0) begin
            nVec++; if (InstPC !== 12'(n - 1)) begin nErr++; $display("FAIL straight_pc[%0d]: got %0h want %0h", n, InstPC, n - 1); end
            nVec++; if (InstOut !== romFn(12'(n - 1))) begin nErr++; $display("FAIL straight_inst[%0d]: got %0h want %0h", n, InstOut, romFn(12'(n - 1))); end
         end
         tick();
      end
   endtask

   task test_stall();
      doReset();
      Stall = 1;
      for (int n = 0; n < 5; n++) tick();
      nVec++; if (RomAddr !== 12'h002) begin nErr++; $display("FAIL stall_romaddr: got %0h want 2", RomAddr); end
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h000) begin nErr++; $display("FAIL stall_head: got valid=%0b pc=%0h want 1/0", InstValid, InstPC); end
      Stall = 0;
      for (int k = 0; k < 5; k++) begin
         nVec++; if (InstValid !== 1'b1 || InstPC !== 12'(k)) begin nErr++; $display("FAIL stall_release[%0d]: got valid=%0b pc=%0h want 1/%0h", k, InstValid, InstPC, k); end
         tick();
      end
   endtask

   task test_branch();
      int budget;
      doReset();
      LutWe = 1; LutAddr = 4'd3; LutData = 12'h120;
      tick();
      LutWe = 0;
      budget = 0;
      while (!(InstValid === 1'b1 && InstPC === 12'h005) && budget < 20) begin
         tick();
         budget++;
      end
      nVec++; if (budget >= 20) begin nErr++; $display("FAIL branch_reach_pc5: got pc=%0h want 5 within 20 cycles", InstPC); end
      BranchEn = 1; TargSel = 4'd3;
      tick();
      BranchEn = 0;
      nVec++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL branch_bubble: got valid=%0b want 0", InstValid); end
      tick();
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h120) begin nErr++; $display("FAIL branch_target: got valid=%0b pc=%0h want 1/120", InstValid, InstPC); end
      nVec++; if (InstOut !== romFn(12'h120)) begin nErr++; $display("FAIL branch_inst: got %0h want %0h", InstOut, romFn(12'h120)); end
      tick();
      nVec++; if (InstPC !== 12'h121) begin nErr++; $display("FAIL branch_next: got %0h want 121", InstPC); end
   endtask

   task test_lut_collision();
      LutWe = 1; LutAddr = 4'd3; LutData = 12'h200;
      BranchEn = 1; TargSel = 4'd3;
      tick();
      LutWe = 0; BranchEn = 0;
      tick();
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h120) begin nErr++; $display("FAIL collision_old: got valid=%0b pc=%0h want 1/120", InstValid, InstPC); end
      BranchEn = 1; TargSel = 4'd3;
      tick();
      BranchEn = 0;
      tick();
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h200) begin nErr++; $display("FAIL collision_new: got valid=%0b pc=%0h want 1/200", InstValid, InstPC); end
   endtask

   task test_halt_branch();
      int budget;
      logic [P-1:0] saved;
      doReset();
      budget = 0;
      while (CycleCt !== 16'd10 && budget < 20) begin
         tick();
         budget++;
      end
      nVec++; if (budget >= 20 || InstValid !== 1'b1) begin nErr++; $display("FAIL halt_reach: got cyc=%0d valid=%0b want 10/1", CycleCt, InstValid); end
      saved = RomAddr;
      Halt = 1; BranchEn = 1; TargSel = 4'd3;
      tick();
      Halt = 0; BranchEn = 0;
      for (int k = 0; k < 4; k++) begin
         nVec++; if (Done !== 1'b1) begin nErr++; $display("FAIL halt_done[%0d]: got %0b want 1", k, Done); end
         nVec++; if (InstValid !== 1'b0) begin nErr++; $display("FAIL halt_valid[%0d]: got %0b want 0", k, InstValid); end
         nVec++; if (CycleCt !== 16'd11) begin nErr++; $display("FAIL halt_cyclect[%0d]: got %0d want 11", k, CycleCt); end
         nVec++; if (RomAddr !== saved) begin nErr++; $display("FAIL halt_romaddr[%0d]: got %0h want %0h", k, RomAddr, saved); end
         Stall = 1'($urandom_range(0, 1));
         tick();
      end
      Reset = 1;
      #1;
      nVec++; if (Done !== 1'b0 || CycleCt !== 16'd0) begin nErr++; $display("FAIL halt_reset: got done=%0b cyc=%0d want 0/0", Done, CycleCt); end
      modelReset();
      idleInputs();
      Reset = 0;
   endtask

   task test_reset_mid_stall();
      doReset();
      Stall = 1;
      for (int n = 0; n < 4; n++) tick();
      Reset = 1;
      #1;
      nVec++; if (InstValid !== 1'b0 || RomAddr !== 12'h000) begin nErr++; $display("FAIL midstall_reset_q: got valid=%0b addr=%0h want 0/0", InstValid, RomAddr); end
      nVec++; if (CycleCt !== 16'd0 || Done !== 1'b0) begin nErr++; $display("FAIL midstall_reset_cyc: got cyc=%0d done=%0b want 0/0", CycleCt, Done); end
      modelReset();
      idleInputs();
      Reset = 0;
      tick();
      nVec++; if (InstValid !== 1'b1 || InstPC !== 12'h000) begin nErr++; $display("FAIL midstall_first: got valid=%0b pc=%0h want 1/0", InstValid, InstPC); end
      tick();
      nVec++; if (InstPC !== 12'h001) begin nErr++; $display("FAIL midstall_second: got %0h want 1", InstPC); end
   endtask

   task test_random();
      int haltAge;
      doReset();
      haltAge = 0;
      for (int n = 0; n < 600; n++) begin
         nVec++; if (RomAddr !== mPc) begin nErr++; $display("FAIL rand_romaddr[%0d]: got %0h want %0h", n, RomAddr, mPc); end
         nVec++; if (InstValid !== (pcQ.size() > 0)) begin nErr++; $display("FAIL rand_valid[%0d]: got %0b want %0b", n, InstValid, pcQ.size() > 0); end
         nVec++; if (Done !== mHalted) begin nErr++; $display("FAIL rand_done[%0d]: got %0b want %0b", n, Done, mHalted); end
         nVec++; if (CycleCt !== 16'(mCyc)) begin nErr++; $display("FAIL rand_cyclect[%0d]: got %0d want %0d", n, CycleCt, mCyc); end
         if (pcQ.size() > 0) begin
            nVec++; if (InstPC !== pcQ[0] || InstOut !== romFn(pcQ[0])) begin nErr++; $display("FAIL rand_head[%0d]: got pc=%0h inst=%0h want %0h/%0h", n, InstPC, InstOut, pcQ[0], romFn(pcQ[0])); end
         end
         haltAge = mHalted ? haltAge + 1 : 0;
         if (haltAge > 5) begin
            doReset();
            haltAge = 0;
         end
         Stall    = ($urandom_range(0, 99) < 30);
         BranchEn = ($urandom_range(0, 99) < 15);
         Halt     = ($urandom_range(0, 99) < 2);
         TargSel  = 4'($urandom_range(0, 15));
         LutWe    = ($urandom_range(0, 99) < 20);
         LutAddr  = 4'($urandom_range(0, 15));
         LutData  = 12'($urandom);
         tick();
      end
      idleInputs();
   endtask

   task test_small();
      rst2 = 0;
      for (int n = 0; n < 40; n++) begin
         nVec++; if (romAddr2 !== 4'(n)) begin nErr++; $display("FAIL small_wrap[%0d]: got %0h want %0h", n, romAddr2, 4'(n)); end
         nVec++; if (cyc2 !== 4'((n > 15) ? 15 : n)) begin nErr++; $display("FAIL small_sat[%0d]: got %0d want %0d", n, cyc2, (n > 15) ? 15 : n); end
         if (n > 0) begin
            nVec++; if (instValid2 !== 1'b1 || instPc2 !== 4'(n - 1) || instOut2 !== romFn4(4'(n - 1)) || done2 !== 1'b0) begin
               nErr++; $display("FAIL small_head[%0d]: got v=%0b pc=%0h inst=%0h done=%0b want 1/%0h/%0h/0", n, instValid2, instPc2, instOut2, done2, 4'(n - 1), romFn4(4'(n - 1)));
            end
         end
         tick();
      end
   endtask

   initial begin
      rst2 = 1;
      test_reset();
      test_straight();
      test_stall();
      test_branch();
      test_lut_collision();
      test_halt_branch();
      test_reset_mid_stall();
      test_random();
      test_small();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter P, default 12, program counter width.
REQ-002 Parameter W, default 9, instruction width.
REQ-003 Parameter T, default 4, target-select width; branch target table holds 2^T entries of P bits.
REQ-004 Parameter Q, default 2, prefetch queue depth (Q >= 1).
REQ-005 Parameter C, default 16, cycle counter width.
REQ-006 Clk  input  1  single clock; all state changes on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 RomAddr  output  P  fetch address to instruction ROM.
REQ-009 RomData  input  W  ROM word for RomAddr, combinational, same cycle.
REQ-010 Stall  input  1  consumer cannot accept the head instruction this cycle.
REQ-011 BranchEn  input  1  head instruction is a taken branch.
REQ-012 TargSel  input  T  target table index used when a branch is taken.
REQ-013 Halt  input  1  head instruction is a halt.
REQ-014 LutWe, LutAddr[T], LutData[P]  input  write port for the target table.
REQ-015 InstOut  output  W  head-of-queue instruction.
REQ-016 InstPC  output  P  address of InstOut.
REQ-017 InstValid  output  1  InstOut/InstPC are valid.
REQ-018 Done  output  1  halted flag.
REQ-019 CycleCt  output  C  cycles elapsed since reset until halt.

Function
REQ-020 Consume event = InstValid & ~Stall; BranchEn and Halt are ignored without a consume event.
REQ-021 States: RUN, HALTED; only transition is RUN->HALTED on a consume event with Halt=1; HALTED is left only by Reset.
REQ-022 Push = state RUN & (count < Q or consume event) & no taken branch or halt this cycle; a push stores {RomData, RomAddr} at queue tail and increments fetch PC by 1 modulo 2^P (2^P-1 wraps to 0).
REQ-023 Consume event pops the head; push and pop in the same cycle leave count unchanged, including when count = Q.
REQ-024 Taken branch (consume event, BranchEn=1, Halt=0): queue emptied, fetch PC <= table[TargSel]; no push that edge; InstValid=0 the following cycle; target instruction valid two cycles after branch consume (one bubble).
REQ-025 Halt with BranchEn in the same consume event: Halt wins, no redirect.
REQ-026 On entering HALTED: queue emptied, InstValid=0, Done=1, fetch PC and RomAddr hold, no further pushes.
REQ-027 RomAddr = fetch PC at all times.
REQ-028 InstValid = (count > 0); InstOut/InstPC = head entry, don't-care when InstValid=0.
REQ-029 Table write on LutWe at rising edge; a branch in the same cycle reading the same index uses the pre-write value.
REQ-030 Table writes are accepted in both states.
REQ-031 CycleCt increments by 1 each cycle in RUN, saturates at 2^C-1, holds in HALTED (the halting cycle is counted).

Reset
REQ-032 Reset asserted: state RUN, fetch PC 0, queue empty, InstValid 0, Done 0, CycleCt 0, all table entries 0, immediately and independent of Clk.
REQ-033 Reset mid-branch or mid-halt discards the pending operation; first push after release is from address 0.

Verification
REQ-034 Release reset, Stall=0, no branch: RomAddr 0,1,2,...; InstValid from cycle 1; InstPC tracks 0,1,2 one cycle behind RomAddr.
REQ-035 Q=2, Stall=1 for 5 cycles: count reaches 2, RomAddr holds at 2, InstPC stays 0; release Stall -> InstPC 0,1,2 with no gap.
REQ-036 Write table[3]=0x120, then branch with TargSel=3 at InstPC 5: one invalid cycle, next valid InstPC=0x120, no instruction from 6 or 7 delivered.
REQ-037 LutWe to index 3 with 0x200 in same cycle as branch TargSel=3 (old value 0x120): redirect to 0x120; later branch goes to 0x200.
REQ-038 Halt and BranchEn together at CycleCt=10: Done=1 next cycle, InstValid=0, CycleCt frozen at 11, RomAddr frozen.
REQ-039 P=4, straight-line run: RomAddr wraps 15->0; C=4, long run: CycleCt saturates at 15; Reset mid-stall clears all state asynchronously.
